// File: rtl/pulse_param_bank.sv
// pulse_param_bank: UART-framed write/read-back bank of NREG pulse-parameter registers
// Frame is NB data bytes (LSB first), CMD (bit7 read, [6:0] index), then an 8-bit SUM.
module pulse_param_bank #(
   parameter int NREG = 16,
   parameter int DW = 32,
   parameter int TIMEOUT = 2010000,
   parameter logic [NREG*DW-1:0] INIT = '0,
   parameter logic [7:0] ACK = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_byte,
   input  logic                 rx_valid,
   input  logic                 rx_error,
   output logic [7:0]           tx_byte,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [NREG*DW-1:0]   regs,
   output logic [NREG-1:0]      upd_strobe,
   output logic                 frame_err,
   output logic                 busy
);
   localparam int NB = DW / 8;
   localparam int CW = NB > 1 ? $clog2(NB) : 1;
   localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(NB + 2);
   localparam logic [CW-1:0] LAST = CW'(NB - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
   localparam logic [7:0] NREG8 = 8'(NREG);

   typedef enum logic [2:0] {RX_DATA, RX_CMD, RX_SUM, EXEC, TX, TX_WAIT} state_t;
   state_t state, state_n;
   logic [DW-1:0] r [NREG];
   logic [DW-1:0] data;
   logic [DW+7:0] tx_sr;
   logic [7:0] cmd, sum;
   logic sum_ok, first;
   logic [CW-1:0] cnt;
   logic [TW-1:0] to_cnt;
   logic [LW-1:0] tx_left;
   logic rx_st, active, expire, abort, take, bad, rd;
   logic [IW-1:0] idx;

   for (genvar i = 0; i < NREG; i++) begin : g_regs
      assign regs[i*DW +: DW] = r[i];
   end

   assign rx_st = state == RX_DATA || state == RX_CMD || state == RX_SUM;
   assign active = (state == RX_DATA && cnt != '0) || state == RX_CMD || state == RX_SUM;
   assign expire = active && to_cnt >= TO_MAX;
   assign abort = rx_st && (rx_error || expire);
   assign take = rx_st && rx_valid && !abort;
   assign idx = cmd[IW-1:0];
   assign rd = cmd[7];
   assign bad = !sum_ok || {1'b0, cmd[6:0]} >= NREG8;
   assign busy = !(state == RX_DATA && cnt == '0);

   always_comb begin
      state_n = state;
      case (state)
         RX_DATA: state_n = take && cnt == LAST ? RX_CMD : RX_DATA;
         RX_CMD:  state_n = take ? RX_SUM : RX_CMD;
         RX_SUM:  state_n = take ? EXEC : RX_SUM;
         EXEC:    state_n = TX;
         TX:      state_n = !tx_busy ? TX_WAIT : TX;
         TX_WAIT: state_n = first || tx_busy ? TX_WAIT : tx_left == '0 ? RX_DATA : TX;
         default: state_n = RX_DATA;
      endcase
      if (abort) state_n = RX_DATA;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RX_DATA;
         for (int k = 0; k < NREG; k++) r[k] <= INIT[k*DW +: DW];
         data <= '0;
         tx_sr <= '0;
         cmd <= '0;
         sum <= '0;
         sum_ok <= 1'b0;
         first <= 1'b0;
         cnt <= '0;
         to_cnt <= '0;
         tx_left <= '0;
         tx_byte <= '0;
         tx_start <= 1'b0;
         upd_strobe <= '0;
         frame_err <= 1'b0;
      end else begin
         state <= state_n;
         tx_start <= 1'b0;
         upd_strobe <= '0;
         frame_err <= abort;
         to_cnt <= rx_valid || !active || abort ? '0 : to_cnt + 1'b1;
         if (abort) begin
            cnt <= '0;
            sum <= '0;
         end else if (take) begin
            if (state != RX_SUM) sum <= sum + rx_byte;
            if (state == RX_DATA) begin
               data[8*int'(cnt) +: 8] <= rx_byte;
               cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            end
            if (state == RX_CMD) cmd <= rx_byte;
            if (state == RX_SUM) sum_ok <= rx_byte == sum;
         end
         if (state == EXEC) begin
            sum <= '0;
            frame_err <= bad;
            tx_sr <= {!bad && rd ? r[idx] : '0, !sum_ok ? 8'hE1 : bad ? 8'hE2 : ACK};
            tx_left <= !bad && rd ? LW'(NB + 1) : LW'(1);
            if (!bad && !rd) begin
               r[idx] <= data;
               upd_strobe <= NREG'(1) << idx;
            end
         end
         // tx_byte only changes here, so it stays put for the whole UART byte
         if (state == TX && !tx_busy) begin
            tx_byte <= tx_sr[7:0];
            tx_sr <= tx_sr >> 8;
            tx_left <= tx_left - 1'b1;
            tx_start <= 1'b1;
            first <= 1'b1;
         end
         if (state == TX_WAIT) first <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pulse_param_bank.sv
// tb_pulse_param_bank: directed and random frames against a register-array model with a UART stub
module tb_pulse_param_bank;
   localparam int NREG = 16;
   localparam int DW = 32;
   localparam int TO = 50;

   function automatic logic [NREG*DW-1:0] init_vec();
      logic [NREG*DW-1:0] v;
      for (int i = 0; i < NREG; i++) v[i*DW +: DW] = {16'hC0DE, 16'(i)};
      return v;
   endfunction
   localparam logic [NREG*DW-1:0] INIT_V = init_vec();

   logic clk = 0, rst = 1, rx_valid = 0, rx_error = 0, tx_busy = 0;
   logic [7:0] rx_byte = 0;
   logic [7:0] tx_byte;
   logic tx_start, frame_err, busy;
   logic [NREG*DW-1:0] regs;
   logic [NREG-1:0] upd_strobe;

   always #5 clk = ~clk;

   pulse_param_bank #(.NREG(NREG), .DW(DW), .TIMEOUT(TO), .INIT(INIT_V), .ACK(8'hA5)) dut (
      .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
      .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .regs(regs),
      .upd_strobe(upd_strobe), .frame_err(frame_err), .busy(busy)
   );

   int vec = 0, err = 0;
   logic [31:0] m [NREG];
   logic [7:0] txlog [$];
   int fe_cnt = 0, upd_cnt = 0, viol = 0, bcnt = 0;

   // UART transmitter stub plus pulse counters
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            bcnt = 0;
            tx_busy = 0;
         end else begin
            if (frame_err) fe_cnt++;
            if (upd_strobe != '0) upd_cnt++;
            if ($countones(upd_strobe) > 1) viol++;
            if (tx_start) begin
               if (tx_busy) viol++;
               txlog.push_back(tx_byte);
               tx_busy = 1;
               bcnt = $urandom_range(1, 5);
            end else if (bcnt > 0) begin
               bcnt--;
               if (bcnt == 0) tx_busy = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NREG; i++) m[i] = 32'hC0DE_0000 | i;
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < NREG; i++) chk($sformatf("%s_reg%0d", tag, i), regs[i*DW +: DW], m[i]);
   endtask

   task automatic send(input logic [7:0] b, input bit gap);
      @(negedge clk);
      rx_byte = b;
      rx_valid = 1;
      @(negedge clk);
      rx_valid = 0;
      if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic frame(input logic [31:0] d, input logic [7:0] c, input logic [7:0] s);
      logic [7:0] good;
      logic [7:0] exp [$];
      int base, fe0, up0, idx;
      bit ok, wr;
      good = d[7:0] + d[15:8] + d[23:16] + d[31:24] + c;
      idx = int'(c[6:0]);
      base = txlog.size();
      fe0 = fe_cnt;
      up0 = upd_cnt;
      exp = {};
      wr = 0;
      if (s != good) exp.push_back(8'hE1);
      else if (idx >= NREG) exp.push_back(8'hE2);
      else begin
         exp.push_back(8'hA5);
         wr = !c[7];
         if (c[7]) for (int k = 0; k < 4; k++) exp.push_back(m[idx][8*k +: 8]);
      end
      for (int k = 0; k < 4; k++) send(d[8*k +: 8], 1);
      send(c, 1);
      send(s, 0);
      if (wr) begin
         chk("wr_before", regs[idx*DW +: DW], m[idx]);
         @(negedge clk);
         chk("wr_latency", regs[idx*DW +: DW], d);
         chk("upd_strobe", upd_strobe, 16'(1) << idx);
         m[idx] = d;
      end
      ok = 0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (txlog.size() - base >= exp.size() && !busy) begin
            ok = 1;
            break;
         end
      end
      chk("resp_done", ok, 1);
      chk("resp_len", txlog.size() - base, exp.size());
      for (int k = 0; k < exp.size(); k++)
         if (base + k < txlog.size()) chk($sformatf("resp_byte%0d", k), txlog[base+k], exp[k]);
      chk("frame_err_cnt", fe_cnt - fe0, exp[0] != 8'hA5);
      chk("upd_cnt", upd_cnt - up0, wr);
      chk_regs("post");
   endtask

   initial begin
      int fe0, base;
      bit seen;
      logic [31:0] d;
      logic [7:0] c, g;
      reset_model();
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_upd", upd_strobe, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);
      chk_regs("rst");
      rst = 0;
      repeat (2) @(negedge clk);

      frame(32'h0000_00C8, 8'h02, 8'hCA);
      frame(32'h0, 8'h82, 8'h82);
      frame(32'h0000_00C8, 8'h02, 8'hFF);
      frame(32'h0000_0001, 8'h10, 8'h11);

      fe0 = fe_cnt;
      base = txlog.size();
      send(8'h11, 1);
      send(8'h22, 0);
      chk("to_busy", busy, 1);
      repeat (TO - 3) @(negedge clk);
      chk("to_early", fe_cnt - fe0, 0);
      repeat (8) @(negedge clk);
      chk("to_fe", fe_cnt - fe0, 1);
      chk("to_idle", busy, 0);
      chk("to_no_tx", txlog.size() - base, 0);
      frame(32'h0000_0005, 8'h03, 8'h08);

      fe0 = fe_cnt;
      send(8'h77, 1);
      send(8'h66, 1);
      @(negedge clk);
      rx_error = 1;
      @(negedge clk);
      rx_error = 0;
      @(negedge clk);
      chk("rxerr_fe", fe_cnt - fe0, 1);
      chk("rxerr_idle", busy, 0);
      frame(32'hDEAD_BEEF, 8'h07, 8'hDE + 8'hAD + 8'hBE + 8'hEF + 8'h07);
      frame(32'h0, 8'h87, 8'h87);

      repeat (30) begin
         d = $urandom;
         c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 17))};
         g = d[7:0] + d[15:8] + d[23:16] + d[31:24] + c;
         if ($urandom_range(0, 7) == 0) g = g + 8'($urandom_range(1, 255));
         frame(d, c, g);
      end

      send(8'h33, 1);
      send(8'h44, 1);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("rstf_busy", busy, 0);
      chk("rstf_fe", frame_err, 0);
      reset_model();
      chk_regs("rstf");
      @(negedge clk);
      rst = 0;
      frame(32'h1234_5678, 8'h09, 8'h12 + 8'h34 + 8'h56 + 8'h78 + 8'h09);

      for (int k = 0; k < 4; k++) send(8'h00, 1);
      send(8'h89, 1);
      send(8'h89, 0);
      seen = 0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         #1;
         if (tx_start) begin
            seen = 1;
            break;
         end
      end
      chk("rstt_seen", seen, 1);
      #1 rst = 1;
      #1;
      chk("rstt_tx_start", tx_start, 0);
      chk("rstt_tx_byte", tx_byte, 0);
      chk("rstt_busy", busy, 0);
      reset_model();
      chk_regs("rstt");
      @(negedge clk);
      rst = 0;
      repeat (5) @(negedge clk);
      frame(32'h0000_00AB, 8'h0F, 8'hBA);
      frame(32'h0, 8'h8F, 8'h8F);
      frame(32'h0, 8'h89, 8'h89);

      chk("proto_viol", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pulse_param_bank.md
Name: pulse_param_bank

Overview:
- Parametrised successor to the pulse-sequencer UART control block: receives framed command packets as a byte stream from the UART, then writes or reads back one of NREG pulse-parameter registers of DW bits each (period, widths, delays, CPMG count, nutation, blocking).
- Adds what the previous generation lacked: checksum verification, an address field, register read-back, error status, an inter-byte timeout and per-register update strobes.
- Sits between the UART byte interface and the pulse generator. The pulse generator slices `regs` for its parameters.

Parameters:
- NREG, 16, number of parameter registers (1..128).
- DW, 32, register width in bits; must be a multiple of 8. Derived NB = DW/8 data bytes per frame.
- TIMEOUT, 2010000, maximum idle clk cycles between bytes of one frame (about 10 ms at 201 MHz).
- INIT, 0, NREG*DW-bit flattened reset values; register i is INIT[i*DW +: DW].
- ACK, 8'hA5, status byte for a successful command.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_byte  in  8  byte from UART, valid when rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- rx_error  in  1  one-cycle pulse on a UART framing error
- tx_byte  out  8  byte to UART, held stable from tx_start until the byte completes
- tx_start  out  1  one-cycle request to transmit tx_byte
- tx_busy  in  1  UART transmitter active
- regs  out  NREG*DW  flattened register contents
- upd_strobe  out  NREG  one-hot, one-cycle pulse when register i is written
- frame_err  out  1  one-cycle pulse on checksum error, bad address, timeout or rx_error
- busy  out  1  high in any state other than RX_DATA with byte count 0

Behaviour:
- Reset (async, immediate):
  - regs=INIT; tx_byte=0; tx_start=0; upd_strobe=0; frame_err=0; busy=0.
  - State RX_DATA, byte count 0, timeout counter 0.
- Frame, host to block, in this order:
  - NB data bytes, LSB first.
  - CMD byte: bit7=1 read, bit7=0 write; bits[6:0]=register index.
  - SUM byte = 8-bit sum (mod 256) of the NB data bytes and CMD.
- States:
  - RX_DATA: each rx_valid stores rx_byte into data[8*cnt +: 8] and increments cnt. When the NB-th byte arrives, go to RX_CMD.
  - RX_CMD: on rx_valid latch CMD, go to RX_SUM.
  - RX_SUM: on rx_valid compare rx_byte with the running sum, go to EXEC.
  - EXEC, exactly one cycle, evaluated in this priority order:
    - Checksum mismatch: status=8'hE1, frame_err pulse.
    - Else index >= NREG: status=8'hE2, frame_err pulse.
    - Else write: regs[idx] <= data, upd_strobe[idx]=1 for this cycle, status=ACK.
    - Else read: snapshot regs[idx] into the tx shift register, status=ACK.
    - Then go to TX.
  - TX: when tx_busy=0, drive tx_byte and a 1-cycle tx_start, go to TX_WAIT.
  - TX_WAIT: ignore tx_busy in the first cycle after tx_start, then wait for tx_busy=0.
    - After the status byte: a successful read sends the NB snapshot bytes LSB first, each through TX/TX_WAIT.
    - Otherwise return to RX_DATA with cnt=0.
- Write latency: regs updated on the clk edge that ends EXEC, which is 2 cycles after the SUM byte's rx_valid.
- Running checksum accumulates on every accepted data and CMD byte; it clears to 0 on frame start, abort and completion.
- Timeout:
  - The counter runs while cnt>0 or the state is RX_CMD/RX_SUM, and clears on every rx_valid.
  - When it reaches TIMEOUT: discard the partial frame, pulse frame_err, return to RX_DATA cnt=0. No response is sent.
- rx_error in any RX state: same abort as a timeout.
- rx_valid during EXEC/TX/TX_WAIT: byte dropped, no effect on the next frame.
- rx_valid coinciding with a timeout expiry: the abort wins and the byte is dropped.
- Reset mid-transmit: tx_start low immediately; partial frame and pending response discarded; regs return to INIT.
- Read snapshot is taken in EXEC; the read returns the value current at EXEC.

Test Plan:
- Write, NREG=16, DW=32: send C8 00 00 00 02 CA -> tx A5; regs[95:64]=32'h000000C8 exactly 2 cycles after the last rx_valid; upd_strobe=16'h0004 for one cycle; other registers unchanged.
- Read-back: after the write above, send 00 00 00 00 82 82 -> tx sequence A5 C8 00 00 00; 5 tx_start pulses, each issued only while tx_busy=0.
- Bad checksum: send C8 00 00 00 02 FF -> tx E1; frame_err pulses once; regs[95:64] unchanged; no upd_strobe.
- Bad address: send 01 00 00 00 10 11 (index 16) -> tx E2; frame_err pulses; no register changes.
- Timeout recovery: send 11 22, idle TIMEOUT+1 cycles -> frame_err pulses and nothing is transmitted. Then a full write 05 00 00 00 03 08 -> tx A5; regs[127:96]=5.
- Async reset asserted mid-frame and mid-TX -> outputs return to reset values with no clk edge; regs=INIT; the next valid frame is processed normally.
